switch_reduce_debounced: RTL and testbench
==========================================

// Module: switch_reduce_debounced
// PURPOSE
// - Parametrised successor of the board switch-reduction logic: WIDTH raw switches are
//   synchronised, debounced per bit, held in an output register, then reduced to NAND/NOR/XNOR lights.
// - Sits between board slide switches and LEDs. Adds a freeze control and a change strobe.
// PARAMETERS
// - WIDTH            4   number of switch inputs (>=2)
// - DEBOUNCE_CYCLES  16  consecutive differing cycles required to accept a bit change (>=1)
// - CNT_W            8   width of event_count (SR_EVENT_COUNT_EN only)
// PORTS
// - clk          in   1        single clock; all state on rising edge
// - reset        in   1        synchronous, active-high reset
// - switches     in   WIDTH    raw asynchronous switch levels
// - hold         in   1        1 = freeze debounced/lights/changed outputs
// - debounced    out  WIDTH    registered debounced switch vector (debounced_q)
// - lights       out  3        [2]=~&debounced_q, [1]=~|debounced_q, [0]=~^debounced_q
// - changed      out  1        1-cycle pulse when debounced_q is updated to a new value
// - event_count  out  CNT_W    saturating count of changed pulses (SR_EVENT_COUNT_EN only)
// BEHAVIOUR
// - Reset: sync regs, stable bits, counters, debounced_q = 0; changed = 0; event_count = 0.
//   lights = 3'b111 after reset.
// - Sync: 2-flop synchroniser per bit (sync1 -> sync2).
// - Debounce, per bit: sync2==stable -> cnt<=0.
//   sync2!=stable and cnt<DEBOUNCE_CYCLES-1 -> cnt++.
//   sync2!=stable and cnt==DEBOUNCE_CYCLES-1 -> stable<=sync2, cnt<=0.
//   cnt width = $clog2(DEBOUNCE_CYCLES+1); the counter never wraps.
// - Bounce: if sync2 returns to stable before acceptance, cnt clears and stable is unchanged.
// - Output register, hold==0: debounced_q<=stable; changed<=(stable!=debounced_q).
//   Output register, hold==1: debounced_q kept; changed<=0. Debouncers keep running.
// - Releasing hold: on the next edge, debounced_q takes the current stable value.
//   changed pulses if that value differs from the held value.
// - lights are pure combinational reduction of debounced_q (no further latency).
// - Latency: a clean level change at edge 1 (first sampling edge) updates lights at edge DEBOUNCE_CYCLES+3.
// - Independent bits may be accepted on different cycles. Each acceptance is a separate update.
// - Reset mid-debounce wins over everything: all state cleared on that edge.
// CONFIGURATION
// - Macro SR_EVENT_COUNT_EN. Defined: event_count port exists.
//   Increments on every cycle changed==1; saturates at 2^CNT_W-1; reset clears it.
// - Not defined: port and counter absent. All other behaviour identical.
// STRUCTURE
// - Package switch_reduce_pkg: light index constants LIGHT_NAND=2, LIGHT_NOR=1, LIGHT_XNOR=0,
//   and the reset light value 3'b111.
// - Sub-module switch_debouncer (1 bit, params DEBOUNCE_CYCLES). Contains synchroniser, cnt, stable.
//   Instantiated WIDTH times via generate.
// - Top holds debounced_q, changed, reduction logic and the optional event counter.
// TESTING (WIDTH=4, DEBOUNCE_CYCLES=4, CNT_W=2)
// - Reset asserted 2 cycles -> lights=3'b111, debounced=4'h0, changed=0.
// - switches 0->4'hF held -> lights=3'b001 and debounced=4'hF exactly at edge 7.
//   changed=1 for exactly that cycle.
// - switches 4'h0->4'h1 held -> lights=3'b100 after 7 edges.
//   switches[0] high 3 cycles then low -> no change; lights stay 3'b111, changed never 1.
// - hold=1, switches->4'hF, wait 20 cycles -> lights stay 3'b111.
//   Release hold -> next edge lights=3'b001 with one changed pulse.
// - reset asserted at cnt==2 during a change -> all outputs at reset values.
//   Full DEBOUNCE_CYCLES+3 latency re-applies afterwards.
// - SR_EVENT_COUNT_EN: 5 accepted changes -> event_count=3 (saturated); reset -> 0.

Source files
------------

// File: rtl/switch_reduce_pkg.sv
// Shared constants for the switch reduction block: light bit positions and reset light value.
// Latency: none (package only).
// Backpressure: none (package only).
package switch_reduce_pkg;

  // Bit positions inside the 3-bit lights vector
  localparam int LIGHT_NAND = 2;
  localparam int LIGHT_NOR  = 1;
  localparam int LIGHT_XNOR = 0;

  // Reduction of an all-zero vector: NAND=1, NOR=1, XNOR=1
  localparam logic [2:0] LIGHTS_RESET = 3'b111;

endpackage

// File: rtl/switch_debouncer.sv
// One-bit switch conditioner: 2-flop synchroniser followed by a consecutive-cycle debounce counter.
// Latency: a clean change appears on stable DEBOUNCE_CYCLES+2 edges after it is first sampled.
// Backpressure: none; free-running every cycle, synchronous active-high reset.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          stable_q;

  // Two-stage synchroniser for the asynchronous switch level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed from stable for DEBOUNCE_CYCLES consecutive cycles;
  // any return to the stable level before that clears the count (bounce rejection)
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      stable_q <= 1'b0;
    end else if (sync2 == stable_q) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable_q <= sync2;
      cnt      <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/switch_reduce_debounced.sv
// Debounced switch bank reduced to NAND/NOR/XNOR lights, with freeze (hold) and change strobe.
// Latency: clean input change to lights in DEBOUNCE_CYCLES+3 edges; lights combinational from debounced.
// Backpressure: hold freezes the output register while debouncers keep running; optional
// event_count port exists only when SR_EVENT_COUNT_EN is defined.
module switch_reduce_debounced
  import switch_reduce_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] switches,
  input  logic             hold,
  output logic [WIDTH-1:0] debounced,
  output logic [2:0]       lights,
  output logic             changed
`ifdef SR_EVENT_COUNT_EN
  ,
  output logic [CNT_W-1:0] event_count
`endif
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] debounced_q;
  logic             changed_q;

  // One independent conditioner per switch bit
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk   (clk),
      .reset (reset),
      .raw   (switches[i]),
      .stable(stable[i])
    );
  end

  // Output register: follows the debounced bits unless frozen; strobes when the value moves
  always_ff @(posedge clk) begin
    if (reset) begin
      debounced_q <= '0;
      changed_q   <= 1'b0;
    end else if (hold) begin
      changed_q   <= 1'b0;
    end else begin
      debounced_q <= stable;
      changed_q   <= (stable != debounced_q);
    end
  end

  // Pure reductions of the registered vector, no extra latency
  always_comb begin
    lights             = LIGHTS_RESET;
    lights[LIGHT_NAND] = ~&debounced_q;
    lights[LIGHT_NOR]  = ~|debounced_q;
    lights[LIGHT_XNOR] = ~^debounced_q;
  end

  assign debounced = debounced_q;
  assign changed   = changed_q;

`ifdef SR_EVENT_COUNT_EN
  localparam logic [CNT_W-1:0] EVENT_MAX = '1;

  logic [CNT_W-1:0] event_q;

  // Saturating count of change strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      event_q <= '0;
    end else if (changed_q && (event_q != EVENT_MAX)) begin
      event_q <= event_q + 1'b1;
    end
  end

  assign event_count = event_q;
`endif

endmodule

// File: tb/tb_switch_reduce_debounced.sv
// Directed bench for switch_reduce_debounced (WIDTH=4, DEBOUNCE_CYCLES=4, CNT_W=2).
// Expected debounced values are queued when a change is driven and checked on each changed pulse.
// Build with SR_EVENT_COUNT_EN defined to also exercise the saturating event counter.
module tb_switch_reduce_debounced;

  localparam int WIDTH = 4;
  localparam int DEB   = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] switches;
  logic             hold;
  logic [WIDTH-1:0] debounced;
  logic [2:0]       lights;
  logic             changed;
`ifdef SR_EVENT_COUNT_EN
  logic [CNT_W-1:0] event_count;
`endif

  int errors = 0;
  int checks = 0;
  int changed_seen = 0;
  logic [WIDTH-1:0] exp_q[$];

  switch_reduce_debounced #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .switches   (switches),
    .hold       (hold),
    .debounced  (debounced),
    .lights     (lights),
    .changed    (changed)
`ifdef SR_EVENT_COUNT_EN
    ,
    .event_count(event_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference reduction, written independently of the DUT
  function automatic logic [2:0] ref_lights(input logic [WIDTH-1:0] v);
    logic [2:0] r;
    r[2] = (v != {WIDTH{1'b1}});
    r[1] = (v == '0);
    r[0] = ($countones(v) % 2 == 0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every changed pulse must match the next queued expectation
  always @(negedge clk) begin
    if (reset === 1'b0 && changed === 1'b1) begin
      changed_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_changed", {28'h0, debounced}, 32'hFFFF_FFFF);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        chk("sb_debounced", {28'h0, debounced}, {28'h0, e});
        chk("sb_lights", {29'h0, lights}, {29'h0, ref_lights(e)});
      end
    end
  end

  initial begin
    // Reset for 2 cycles
    reset = 1'b1; switches = '0; hold = 1'b0;
    edges(2);
    reset = 1'b0;
    chk("rst_lights", {29'h0, lights}, 32'h7);
    chk("rst_debounced", {28'h0, debounced}, 32'h0);
    chk("rst_changed", {31'h0, changed}, 32'h0);
`ifdef SR_EVENT_COUNT_EN
    chk("rst_event_count", {30'h0, event_count}, 32'h0);
`endif

    // 0 -> F: output moves exactly at edge DEB+3
    switches = 4'hF; exp_q.push_back(4'hF);
    edges(DEB + 2);
    chk("f_before_edge7", {28'h0, debounced}, 32'h0);
    chk("f_changed_before", {31'h0, changed}, 32'h0);
    edges(1);
    chk("f_lights_edge7", {29'h0, lights}, 32'h1);
    chk("f_debounced_edge7", {28'h0, debounced}, 32'hF);
    chk("f_changed_edge7", {31'h0, changed}, 32'h1);
    edges(1);
    chk("f_changed_one_cycle", {31'h0, changed}, 32'h0);

    // Back to 0, then 0 -> 1
    switches = 4'h0; exp_q.push_back(4'h0);
    edges(DEB + 3);
    chk("zero_lights", {29'h0, lights}, 32'h7);
    edges(2);
    switches = 4'h1; exp_q.push_back(4'h1);
    edges(DEB + 3);
    chk("one_lights", {29'h0, lights}, 32'h4);
    chk("one_changed", {31'h0, changed}, 32'h1);
    edges(2);
    switches = 4'h0; exp_q.push_back(4'h0);
    edges(DEB + 5);
    chk("one_back_lights", {29'h0, lights}, 32'h7);

    // Bounce: bit 0 high for 3 cycles only
    changed_seen = 0;
    switches = 4'h1;
    edges(3);
    switches = 4'h0;
    edges(12);
    chk("bounce_lights", {29'h0, lights}, 32'h7);
    chk("bounce_no_changed", changed_seen, 32'h0);

    // Hold freezes the output while debouncers keep running
    hold = 1'b1; switches = 4'hF;
    edges(20);
    chk("hold_lights", {29'h0, lights}, 32'h7);
    chk("hold_debounced", {28'h0, debounced}, 32'h0);
    chk("hold_no_changed", changed_seen, 32'h0);
    exp_q.push_back(4'hF);
    hold = 1'b0;
    edges(1);
    chk("release_lights", {29'h0, lights}, 32'h1);
    chk("release_changed", {31'h0, changed}, 32'h1);
    edges(1);
    chk("release_changed_once", {31'h0, changed}, 32'h0);
    chk("release_pulses", changed_seen, 32'h1);

    // Reset mid-debounce (counter at 2) wins over everything
    switches = 4'h0;
    edges(4);
    chk("mid_still_f", {28'h0, debounced}, 32'hF);
    reset = 1'b1;
    edges(1);
    chk("midrst_debounced", {28'h0, debounced}, 32'h0);
    chk("midrst_lights", {29'h0, lights}, 32'h7);
    chk("midrst_changed", {31'h0, changed}, 32'h0);
`ifdef SR_EVENT_COUNT_EN
    chk("midrst_event_count", {30'h0, event_count}, 32'h0);
`endif
    reset = 1'b0; switches = 4'hF; exp_q.push_back(4'hF);
    edges(DEB + 2);
    chk("post_rst_before", {28'h0, debounced}, 32'h0);
    edges(1);
    chk("post_rst_edge7", {29'h0, lights}, 32'h1);
    edges(1);
`ifdef SR_EVENT_COUNT_EN
    chk("event_count_one", {30'h0, event_count}, 32'h1);
`endif

    // Four more accepted changes (five since reset): counter saturates
    for (int k = 0; k < 4; k++) begin
      switches = (k % 2 == 0) ? 4'h0 : 4'hF;
      exp_q.push_back(switches);
      edges(DEB + 5);
    end
    chk("toggle_final_lights", {29'h0, lights}, 32'h1);
`ifdef SR_EVENT_COUNT_EN
    chk("event_count_sat", {30'h0, event_count}, 32'h3);
    reset = 1'b1;
    edges(1);
    reset = 1'b0;
    chk("event_count_reset", {30'h0, event_count}, 32'h0);
`endif

    edges(2);
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
